regfile_sweep: RTL and testbench
================================

# regfile_sweep

Parametrised register file for the single-cycle datapath with two asynchronous read ports and one synchronous write port. It adds a sequenced clear operation (one register per cycle, BUSY-flagged), an optional hardwired-zero register, and optional same-cycle write-to-read bypass. It sits between the instruction decoder (addresses, WRITE) and the ALU (OUT1/OUT2 operands, IN result).

## Interface
- DATA_W, 8, register width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes
- CLK  input  1  rising-edge clock
- RESET  input  1  asynchronous, active-high reset
- IN  input  DATA_W  write data
- INADDRESS  input  ADDR_W  write address
- WRITE  input  1  write enable, sampled at rising CLK
- OUT1ADDRESS  input  ADDR_W  read port 1 address
- OUT2ADDRESS  input  ADDR_W  read port 2 address
- CLEAR  input  1  start a sweep clear, sampled at rising CLK
- OUT1  output  DATA_W  read port 1 data, combinational
- OUT2  output  DATA_W  read port 2 data, combinational
- BUSY  output  1  sweep clear in progress
- WR_DROP  output  1  one-cycle pulse: a write was discarded

## Operation
- RESET high: all registers 0, state IDLE, sweep pointer 0, BUSY 0, WR_DROP 0, immediately (not clock-gated).
- FSM states: IDLE, SWEEP.
- IDLE: WRITE=1 commits IN to regfile[INADDRESS] at the edge. CLEAR=1 moves to SWEEP, pointer := 0.
- SWEEP: each edge clears regfile[pointer] and increments it; the edge clearing DEPTH-1 returns to IDLE, pointer := 0.
- WRITE=1 in SWEEP: write discarded, WR_DROP=1 for the following cycle.
- CLEAR=1 while in SWEEP: ignored; no restart.
- WRITE and CLEAR together in IDLE: write commits, sweep starts; the written register is later cleared.
- ZERO_REG=1: writes to address 0 are silently ignored (no WR_DROP); OUT1/OUT2 return 0 for address 0.
- Reads in SWEEP return current contents: cleared registers read 0, uncleared keep old values.
- OUT1ADDRESS == OUT2ADDRESS is legal; both outputs carry identical data.
- Pointer is ADDR_W bits; wrap from DEPTH-1 is never used as a state (exit is explicit).

## Timing
- Write latency: value visible on OUT1/OUT2 after the committing edge (same cycle only with bypass).
- Read latency: zero cycles, combinational from address and storage.
- Sweep: CLEAR sampled at edge k → BUSY=1 after edge k; registers 0..DEPTH-1 cleared at edges k+1..k+DEPTH; BUSY=0 after edge k+DEPTH. BUSY is high for exactly DEPTH cycles.
- A new CLEAR is accepted at edge k+DEPTH+1 at the earliest.
- WR_DROP is registered: high for the cycle after the discarded write edge.
- RESET asserted mid-sweep: aborts immediately to IDLE with all registers 0.

## Configuration
- REGFILE_BYPASS_EN defined: while IDLE and WRITE=1, a read port whose address equals INADDRESS outputs IN combinationally (except address 0 when ZERO_REG=1, which stays 0). No forwarding in SWEEP.
- Undefined: read ports always return stored contents; a same-cycle write is seen only after the edge.

## Structure
- Package regfile_pkg: state enum (ST_IDLE, ST_SWEEP), default DATA_W/ADDR_W constants.
- Sub-module regfile_sweep_ctrl: FSM, pointer, BUSY, WR_DROP, write-qualify signal. Storage and read muxes stay in the top.

## Test plan
- Reset then write 8'd25 to r3, 8'd7 to r5; read OUT1=r3, OUT2=r5 → 25, 7 after the write edges.
- Bypass (REGFILE_BYPASS_EN): WRITE r2=8'd99 with OUT1ADDRESS=2 same cycle → OUT1=99 before the edge; undefined → old value (0).
- Fill r0..r7 with 8'd1..8'd8, pulse CLEAR → BUSY high exactly 8 cycles; r0 reads 0 after 1st sweep edge, r7 reads 8 until the 8th.
- WRITE r4=8'd55 during SWEEP → WR_DROP pulses once, r4 ends 0; CLEAR mid-sweep doesn't extend BUSY.
- ZERO_REG=1: write 8'd200 to r0 → OUT1 reads 0, WR_DROP stays 0.
- Assert RESET at sweep cycle 3 with r6=8'd44 → all outputs 0, BUSY 0 without a clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the sweep-clear register file.
package regfile_pkg;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SWEEP
    } state_e;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 3;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_sweep_ctrl.sv
// Sweep-clear sequencer: FSM, clear pointer, BUSY, WR_DROP and write qualification.
module regfile_sweep_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_write,
    input  logic              i_clear,
    input  logic [ADDR_W-1:0] i_inaddress,
    output logic              o_wr_en,
    output logic              o_clr_en,
    output logic [ADDR_W-1:0] o_ptr,
    output logic              o_busy,
    output logic              o_wr_drop
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_next;
    logic              r_wr_drop;
    logic              w_wr_drop_next;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_wr_drop <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ptr     <= w_ptr_next;
            r_wr_drop <= w_wr_drop_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_ptr_next     = r_ptr;
        w_wr_drop_next = 1'b0;
        o_wr_en        = 1'b0;
        o_clr_en       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                // A write to a hardwired zero register is ignored silently, not dropped.
                o_wr_en = i_write && !(ZERO_REG && (i_inaddress == '0));
                if (i_clear) begin
                    w_state_next = ST_SWEEP;
                    w_ptr_next   = '0;
                end
            end
            ST_SWEEP: begin
                o_clr_en       = 1'b1;
                w_wr_drop_next = i_write;
                if (r_ptr == LAST_ADDR) begin
                    w_state_next = ST_IDLE;
                    w_ptr_next   = '0;
                end else begin
                    w_ptr_next = r_ptr + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_ptr_next   = '0;
            end
        endcase
    end

    assign o_ptr     = r_ptr;
    assign o_busy    = (r_state == ST_SWEEP);
    assign o_wr_drop = r_wr_drop;

endmodule

// File: rtl/regfile_sweep.sv
// Register file, 2 async read / 1 sync write, with sequenced sweep clear.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports while idle.
module regfile_sweep
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_in,
    input  logic [ADDR_W-1:0] i_inaddress,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_out1address,
    input  logic [ADDR_W-1:0] i_out2address,
    input  logic              i_clear,
    output logic [DATA_W-1:0] o_out1,
    output logic [DATA_W-1:0] o_out2,
    output logic              o_busy,
    output logic              o_wr_drop
);

    localparam int unsigned DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_en;
    logic              w_clr_en;
    logic [ADDR_W-1:0] w_ptr;
    logic              w_busy;
    logic [DATA_W-1:0] w_out1;
    logic [DATA_W-1:0] w_out2;

    regfile_sweep_ctrl #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_ctrl (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_write     (i_write),
        .i_clear     (i_clear),
        .i_inaddress (i_inaddress),
        .o_wr_en     (w_wr_en),
        .o_clr_en    (w_clr_en),
        .o_ptr       (w_ptr),
        .o_busy      (w_busy),
        .o_wr_drop   (o_wr_drop)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clr_en) begin
            r_mem[w_ptr] <= '0;
        end else if (w_wr_en) begin
            r_mem[i_inaddress] <= i_in;
        end
    end

    always_comb begin
        w_out1 = r_mem[i_out1address];
        w_out2 = r_mem[i_out2address];
`ifdef REGFILE_BYPASS_EN
        if (!w_busy && i_write) begin
            if (i_out1address == i_inaddress) w_out1 = i_in;
            if (i_out2address == i_inaddress) w_out2 = i_in;
        end
`endif
        // Zero override last so bypass can never leak data onto register 0.
        if (ZERO_REG) begin
            if (i_out1address == '0) w_out1 = '0;
            if (i_out2address == '0) w_out2 = '0;
        end
    end

    assign o_out1 = w_out1;
    assign o_out2 = w_out2;
    assign o_busy = w_busy;

endmodule

// File: tb/tb_regfile_sweep.sv
// Randomized and directed checks of regfile_sweep (plain and hardwired-zero builds) against a model.
module tb_regfile_sweep;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] din;
    logic [AW-1:0] inaddr;
    logic          write;
    logic [AW-1:0] rd1;
    logic [AW-1:0] rd2;
    logic          clear;

    logic [DW-1:0] out1, out2, z_out1, z_out2;
    logic          busy, wr_drop, z_busy, z_wr_drop;

    always #5 clk = ~clk;

    regfile_sweep #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0)) u_dut (
        .i_clk(clk), .i_reset(reset), .i_in(din), .i_inaddress(inaddr), .i_write(write),
        .i_out1address(rd1), .i_out2address(rd2), .i_clear(clear),
        .o_out1(out1), .o_out2(out2), .o_busy(busy), .o_wr_drop(wr_drop)
    );

    regfile_sweep #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) u_dut_z (
        .i_clk(clk), .i_reset(reset), .i_in(din), .i_inaddress(inaddr), .i_write(write),
        .i_out1address(rd1), .i_out2address(rd2), .i_clear(clear),
        .o_out1(z_out1), .o_out2(z_out2), .o_busy(z_busy), .o_wr_drop(z_wr_drop)
    );

    // Reference model: register contents, sweep progress and the pending drop flag.
    logic [DW-1:0] m_mem  [DEPTH];
    logic [DW-1:0] mz_mem [DEPTH];
    bit            m_sweep;
    int            m_idx;
    bit            m_drop;

    int n_checks = 0;
    int n_errors = 0;
    int busy_seen;
    int drop_seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input bit zero, input logic [AW-1:0] a);
        if (zero && a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (!m_sweep && write && a == inaddr) return din;
`endif
        return zero ? mz_mem[a] : m_mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            mz_mem[i] = '0;
        end
        m_sweep = 0;
        m_idx   = 0;
        m_drop  = 0;
    endtask

    task automatic model_step();
        if (!m_sweep) begin
            m_drop = 0;
            if (write) begin
                m_mem[inaddr] = din;
                if (inaddr != 0) mz_mem[inaddr] = din;
            end
            if (clear) begin
                m_sweep = 1;
                m_idx   = 0;
            end
        end else begin
            m_drop        = write;
            m_mem[m_idx]  = '0;
            mz_mem[m_idx] = '0;
            m_idx++;
            if (m_idx == DEPTH) m_sweep = 0;
        end
    endtask

    task automatic check_outputs(input string ctx);
        check_eq({ctx, ".out1"},      out1,      exp_rd(0, rd1));
        check_eq({ctx, ".out2"},      out2,      exp_rd(0, rd2));
        check_eq({ctx, ".z_out1"},    z_out1,    exp_rd(1, rd1));
        check_eq({ctx, ".z_out2"},    z_out2,    exp_rd(1, rd2));
        check_eq({ctx, ".busy"},      busy,      m_sweep);
        check_eq({ctx, ".wr_drop"},   wr_drop,   m_drop);
        check_eq({ctx, ".z_busy"},    z_busy,    m_sweep);
        check_eq({ctx, ".z_wr_drop"}, z_wr_drop, m_drop);
    endtask

    // One clock: drive at negedge, check just after, then advance the model at the edge.
    task automatic cyc(input string ctx, input bit w, input logic [AW-1:0] wa,
                       input logic [DW-1:0] d, input bit c,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        @(negedge clk);
        write  = w;
        inaddr = wa;
        din    = d;
        clear  = c;
        rd1    = a1;
        rd2    = a2;
        #1;
        check_outputs(ctx);
        if (busy) busy_seen++;
        if (wr_drop) drop_seen++;
        @(posedge clk);
        model_step();
    endtask

    initial begin
        reset = 1'b1; write = 0; clear = 0; din = '0; inaddr = '0; rd1 = '0; rd2 = '0;
        model_reset();
        #2;
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Basic writes and reads
        cyc("wr3", 1, 3, 8'd25, 0, 3, 5);
        cyc("wr5", 1, 5, 8'd7, 0, 3, 5);
        cyc("rd35", 0, 0, 8'd0, 0, 3, 5);
        check_eq("r3_value", out1, 32'd25);
        check_eq("r5_value", out2, 32'd7);

        // Same-cycle write/read of r2
        cyc("byp", 1, 2, 8'd99, 0, 2, 2);
        cyc("byp_after", 0, 0, 8'd0, 0, 2, 2);

        // Fill and sweep; BUSY must stay high exactly DEPTH cycles
        for (int i = 0; i < DEPTH; i++) cyc("fill", 1, AW'(i), DW'(i + 1), 0, AW'(i), 7);
        cyc("clr", 0, 0, 8'd0, 1, 0, 7);
        busy_seen = 0;
        for (int i = 0; i < DEPTH + 2; i++) cyc("sweep", 0, 0, 8'd0, 0, 0, 7);
        check_eq("busy_len", busy_seen, DEPTH);

        // Write and re-CLEAR during sweep
        for (int i = 0; i < DEPTH; i++) cyc("fill2", 1, AW'(i), DW'(8'h30 + i), 0, 4, 4);
        cyc("clr2", 0, 0, 8'd0, 1, 4, 4);
        busy_seen = 0;
        drop_seen = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            cyc("sweep2", (i == 6), 4, 8'd55, (i == 3), 4, 6);
        end
        check_eq("busy_len2", busy_seen, DEPTH);
        check_eq("drop_cnt", drop_seen, 1);
        check_eq("r4_cleared", out1, 32'd0);

        // Register 0 write: hardwired-zero build must read 0 and not drop
        drop_seen = 0;
        cyc("wr0", 1, 0, 8'd200, 0, 0, 1);
        cyc("rd0", 0, 0, 8'd0, 0, 0, 1);
        check_eq("zr0_read", z_out1, 32'd0);
        check_eq("r0_read", out1, 32'd200);
        check_eq("zr0_drop", z_wr_drop, 32'd0);

        // Reset mid-sweep must zero everything without a clock edge
        cyc("wr6", 1, 6, 8'd44, 0, 6, 3);
        cyc("clr3", 0, 0, 8'd0, 1, 6, 3);
        for (int i = 0; i < 3; i++) cyc("sweep3", 0, 0, 8'd0, 0, 6, 3);
        @(negedge clk);
        write = 0; clear = 0; rd1 = 6; rd2 = 6;
        #1;
        check_eq("r6_pre_reset", out1, 32'd44);
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("midreset");
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rand", 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                ($urandom_range(0, 15) == 0), AW'($urandom), AW'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
